// File: rtl/fw_seq_pkg.sv
// fw_seq_pkg -- shared types and constants for the forward-pipeline sequencer.
//   state_e      : 2-bit FSM state encoding
//   DIGIT_W_DEF  : default width of the predicted digit
//   CNT_W        : width of the pipeline-latency down-counter
package fw_seq_pkg;

  localparam int DIGIT_W_DEF = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESULT  = 2'd3
  } state_e;

endpackage

// File: rtl/fw_sequencer.sv
// fw_sequencer -- runs one inference through a PIPE_STAGES-deep forward
// pipeline: accepts a request, enables the pipeline for exactly PIPE_STAGES
// cycles, captures the predicted digit and holds it until the consumer takes it.
//
// Optional feature: define FW_SEQ_PERF_CNT_EN to add the 16-bit infer_count
// output (completed result handshakes, wrapping, aborts not counted).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   req_valid  in   inference request (pixel frame stable)
//   req_ready  out  sequencer idle, request can be accepted
//   abort      in   synchronous cancel; wins over everything else
//   fw_en      out  enable for every forward-pipeline register
//   fw_digit   in   predicted digit from the pipeline output register
//   res_valid  out  result held
//   res_ready  in   consumer accepts result
//   res_digit  out  captured digit, kept after handoff
//   busy       out  any state other than IDLE
//   infer_count out (FW_SEQ_PERF_CNT_EN only) completed handshakes
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for a request, pipeline frozen
// ST_RUN     | pipeline enabled, counting down the pipeline latency
// ST_CAPTURE | pipeline frozen, result register loads fw_digit on exit
// ST_RESULT  | result offered to the consumer until res_ready or abort
module fw_sequencer
  import fw_seq_pkg::*;
#(
  parameter int PIPE_STAGES = 4,
  parameter int DIGIT_W     = DIGIT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               abort,
  output logic               fw_en,
  input  logic [DIGIT_W-1:0] fw_digit,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DIGIT_W-1:0] res_digit,
`ifdef FW_SEQ_PERF_CNT_EN
  output logic [15:0]        infer_count,
`endif
  output logic               busy
);

  // Counter holds the remaining RUN cycles minus one, so RUN lasts PIPE_STAGES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PIPE_STAGES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] res_digit_q, res_digit_d;
  logic               accept;
  logic               handoff;

  assign accept  = (state_q == ST_IDLE)   && req_valid && !abort;
  assign handoff = (state_q == ST_RESULT) && res_ready && !abort;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)              state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = abort ? ST_IDLE : ST_RESULT;
      end
      ST_RESULT: begin
        if (abort || res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure functions of the state
  always_comb begin
    req_ready = 1'b0;
    fw_en     = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_RUN:    fw_en     = 1'b1;
      ST_RESULT: res_valid = 1'b1;
      default: ;
    endcase
  end

  // Latency counter and result register
  always_comb begin
    cnt_d       = cnt_q;
    res_digit_d = res_digit_q;
    if (accept) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == ST_RUN) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    // An abort in CAPTURE leaves the previous result untouched.
    if ((state_q == ST_CAPTURE) && !abort) begin
      res_digit_d = fw_digit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      res_digit_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      res_digit_q <= res_digit_d;
    end
  end

  assign res_digit = res_digit_q;

`ifdef FW_SEQ_PERF_CNT_EN
  logic [15:0] infer_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      infer_cnt_q <= '0;
    end else if (handoff) begin
      infer_cnt_q <= infer_cnt_q + 16'd1;
    end
  end

  assign infer_count = infer_cnt_q;
`else
  logic unused_handoff;
  assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_fw_sequencer.sv
// tb_fw_sequencer -- directed and randomized bench for fw_sequencer.
// The reference model tracks an inference by its age in cycles since
// acceptance plus a "result held" flag.
module tb_fw_sequencer;

  localparam int P  = 4;
  localparam int DW = 4;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          req_valid = 1'b0;
  logic          abort     = 1'b0;
  logic          res_ready = 1'b0;
  logic [DW-1:0] fw_digit  = '0;
  logic          req_ready, fw_en, res_valid, busy;
  logic [DW-1:0] res_digit;
`ifdef FW_SEQ_PERF_CNT_EN
  logic [15:0]   infer_count;
`endif

  fw_sequencer #(.PIPE_STAGES(P), .DIGIT_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .abort     (abort),
    .fw_en     (fw_en),
    .fw_digit  (fw_digit),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_digit (res_digit),
`ifdef FW_SEQ_PERF_CNT_EN
    .infer_count (infer_count),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: m_age = cycles since acceptance (0 = no inference running)
  int            m_age  = 0;
  bit            m_hold = 1'b0;
  logic [DW-1:0] m_digit = '0;
  int            m_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_busy;
    exp_busy = (m_age != 0) || m_hold;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(!exp_busy));
    chk({tag, ".busy"},      32'(busy),      32'(exp_busy));
    chk({tag, ".fw_en"},     32'(fw_en),     32'(m_age >= 1 && m_age <= P));
    chk({tag, ".res_valid"}, 32'(res_valid), 32'(m_hold));
    chk({tag, ".res_digit"}, 32'(res_digit), 32'(m_digit));
`ifdef FW_SEQ_PERF_CNT_EN
    chk({tag, ".infer_count"}, 32'(infer_count), 32'(m_done % 65536));
`endif
  endtask

  // Advance model with current inputs, clock one edge, compare.
  task automatic tick(input string tag);
    if (m_hold) begin
      if (abort || res_ready) begin
        if (!abort) m_done++;
        m_hold = 1'b0;
      end
    end else if (m_age == 0) begin
      if (req_valid && !abort) m_age = 1;
    end else if (abort) begin
      m_age = 0;
    end else if (m_age == P + 1) begin
      m_digit = fw_digit;
      m_hold  = 1'b1;
      m_age   = 0;
    end else begin
      m_age++;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_age   = 0;
    m_hold  = 1'b0;
    m_digit = '0;
    m_done  = 0;
  endtask

  initial begin
    // Power-on reset
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("por");
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // Single inference, digit 7
    fw_digit  = 4'd7;
    req_valid = 1'b1;
    tick("acc");
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick("run1");
    chk("t0p6_res_valid", 32'(res_valid), 32'd1);
    chk("t0p6_digit7",    32'(res_digit), 32'd7);

    // Consumer stalls while the pipeline output keeps changing
    for (int i = 0; i < 10; i++) begin
      fw_digit = 4'($urandom_range(0, 15));
      tick("stall");
      chk("stall_fw_en", 32'(fw_en), 32'd0);
    end
    chk("stall_digit7", 32'(res_digit), 32'd7);
    res_ready = 1'b1;
    tick("handoff1");
    res_ready = 1'b0;
    chk("after_handoff_digit", 32'(res_digit), 32'd7);

    // Abort at T0+2
    fw_digit  = 4'd2;
    req_valid = 1'b1;
    tick("acc2");
    req_valid = 1'b0;
    tick("t0p1");
    abort = 1'b1;
    tick("abort");
    abort = 1'b0;
    chk("abort_idle", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) tick("post_abort");
    chk("abort_digit_kept", 32'(res_digit), 32'd7);

    // Abort in IDLE blocks acceptance
    req_valid = 1'b1;
    abort     = 1'b1;
    tick("idle_abort");
    abort     = 1'b0;
    req_valid = 1'b0;
    chk("idle_abort_ready", 32'(req_ready), 32'd1);

    // Reset mid-RUN
    req_valid = 1'b1;
    tick("acc3");
    req_valid = 1'b0;
    tick("run3");
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("mid_reset");
    #2 reset = 1'b1;
    for (int i = 0; i < 8; i++) tick("after_reset");
    chk("after_reset_no_valid", 32'(res_valid), 32'd0);

    // Back-to-back: handoff and next request together in RESULT
    fw_digit  = 4'd9;
    req_valid = 1'b1;
    tick("acc4");
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick("run4");
    chk("b2b_first_digit", 32'(res_digit), 32'd9);
    fw_digit  = 4'd3;
    req_valid = 1'b1;
    res_ready = 1'b1;
    tick("b2b_handoff");
    res_ready = 1'b0;
    chk("b2b_not_busy", 32'(busy), 32'd0);
    tick("b2b_acc");
    req_valid = 1'b0;
    chk("b2b_fw_en", 32'(fw_en), 32'd1);
    for (int i = 0; i < 5; i++) tick("run5");
    chk("b2b_second_digit", 32'(res_digit), 32'd3);
    chk("b2b_second_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick("handoff5");
    res_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      abort     = ($urandom_range(0, 15) == 0);
      res_ready = ($urandom_range(0, 4) < 2);
      fw_digit  = 4'($urandom_range(0, 15));
      tick("rand");
    end
    abort     = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick("drain");
    chk("drain_idle", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fw_sequencer.md
FW_SEQUENCER -- requirements
Module: fw_sequencer

Interface
REQ-001 SHALL have parameter PIPE_STAGES, default 4: number of enabled clock edges the forward pipeline needs to present a result; legal 1..15.
REQ-002 SHALL have parameter DIGIT_W, default 4: width of predicted digit.
REQ-003 SHALL have ports `clk` (input, 1): single clock, rising edge.
REQ-004 SHALL have port `reset` (input, 1): asynchronous, active-low reset.
REQ-005 SHALL have port `req_valid` (input, 1): pixel frame is stable and an inference is requested.
REQ-006 SHALL have port `req_ready` (output, 1): sequencer is idle and accepts a request.
REQ-007 SHALL have port `abort` (input, 1): synchronous cancel of the in-flight inference.
REQ-008 SHALL have port `fw_en` (output, 1): enable to all forward-pipeline registers.
REQ-009 SHALL have port `fw_digit` (input, DIGIT_W): predicted digit from the pipeline output register.
REQ-010 SHALL have port `res_valid` (output, 1): result held.
REQ-011 SHALL have port `res_ready` (input, 1): consumer accepts result.
REQ-012 SHALL have port `res_digit` (output, DIGIT_W): captured digit.
REQ-013 SHALL have port `busy` (output, 1): high in any state except IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN, CAPTURE, RESULT.
REQ-015 `req_ready` SHALL be 1 only in IDLE; request accepted on an edge with req_valid&req_ready&!abort (edge T0).
REQ-016 IDLE -> RUN on acceptance; 4-bit down-counter loaded with PIPE_STAGES-1.
REQ-017 `fw_en` SHALL be 1 exactly in RUN, i.e. cycles T0+1..T0+PIPE_STAGES, and 0 in all other states (pipeline frozen).
REQ-018 RUN -> CAPTURE when counter is 0; else counter decrements each cycle.
REQ-019 In CAPTURE, `res_digit` SHALL register fw_digit on the exiting edge; CAPTURE -> RESULT unconditionally.
REQ-020 `res_valid` SHALL be 1 only in RESULT (first at cycle T0+PIPE_STAGES+2); res_digit stable while res_valid=1.
REQ-021 RESULT -> IDLE on edge with res_ready=1; res_digit retains last value after handoff.
REQ-022 req_valid during RUN/CAPTURE/RESULT SHALL be ignored (not queued); requester holds it until req_ready.
REQ-023 res_ready and req_valid both high in RESULT: result handed off, next request accepted no earlier than following cycle.
REQ-024 abort=1 in RUN or CAPTURE SHALL force IDLE next edge, no result, res_digit unchanged; abort in RESULT drops result (-> IDLE); abort in IDLE blocks acceptance.
REQ-025 abort SHALL take priority over res_ready and counter expiry.

Reset
REQ-026 reset low SHALL asynchronously force IDLE, counter 0, fw_en 0, res_valid 0, res_digit 0, busy 0; req_ready 1 after reset.
REQ-027 Reset asserted mid-RUN SHALL discard the inference; no result emitted after release.

Configuration
REQ-028 With FW_SEQ_PERF_CNT_EN defined, SHALL add output `infer_count` (16): count of completed result handshakes, reset 0, wraps FFFF->0000, not incremented on abort.
REQ-029 Without FW_SEQ_PERF_CNT_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package fw_seq_pkg SHALL hold the state enum (2-bit), DIGIT_W default, counter width constant (4).
REQ-031 No sub-module; FSM and counter in fw_sequencer.

Verification
REQ-032 PIPE_STAGES=4, req_valid pulse at T0, fw_digit=7 -> fw_en high T0+1..T0+4, res_valid at T0+6, res_digit=7, busy high T0+1 until handoff.
REQ-033 res_ready held low 10 cycles, fw_digit toggling -> res_valid and res_digit=7 stable, fw_en 0 throughout.
REQ-034 abort at T0+2 -> IDLE at T0+3, fw_en 0 from T0+3, no res_valid, res_digit keeps previous value.
REQ-035 reset low mid-RUN then released -> all outputs 0, req_ready 1, no spurious res_valid.
REQ-036 Back-to-back: res_ready and req_valid high together in RESULT -> second accept one cycle after handoff, second result correct.
REQ-037 FW_SEQ_PERF_CNT_EN: 3 completed + 1 aborted inference -> infer_count=3; preset 0xFFFF then one completion -> 0x0000.
